// File: rtl/gb_lcd_pkg.sv
// Shared LCD geometry, pixel/address types and the frame-buffer read address helper.
package gb_lcd_pkg;

  localparam int LCD_W   = 160;
  localparam int LCD_H   = 144;
  localparam int LCD_PIX = LCD_W * LCD_H;
  localparam int ADDR_W  = 15;

  typedef logic [1:0]        lcd_pix_t;
  typedef logic [ADDR_W-1:0] lcd_addr_t;

  // Line stride of 160 built from two shifts so no multiplier is inferred.
  function automatic lcd_addr_t lcd_rd_addr(input logic [7:0] x, input logic [7:0] y);
    return (lcd_addr_t'(y) << 7) + (lcd_addr_t'(y) << 5) + lcd_addr_t'(x);
  endfunction

endpackage

// File: rtl/lcd_fb_ram.sv
// Simple dual-port frame-buffer RAM: one write port, one registered read port.
module lcd_fb_ram
  import gb_lcd_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  lcd_pix_t      wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output lcd_pix_t      rdata_o
);

  lcd_pix_t mem [2**AW];
  lcd_pix_t rdata_q;

  // Read data is held between requests so the output stays stable.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_capture.sv
// Captures the PPU pixel stream into a frame buffer with a 1-cycle random-access read port.
// Define LCD_CAPTURE_DOUBLE_BUFFER_EN for tear-free double buffering; otherwise one live bank.
module lcd_capture #(
  parameter int LCD_W = gb_lcd_pkg::LCD_W,
  parameter int LCD_H = gb_lcd_pkg::LCD_H
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 lcd_on_i,
  input  logic                 lcd_clkena_i,
  input  gb_lcd_pkg::lcd_pix_t lcd_data_i,
  input  logic                 rd_req_i,
  input  logic [7:0]           rd_x_i,
  input  logic [7:0]           rd_y_i,
  output gb_lcd_pkg::lcd_pix_t rd_data_o,
  output logic                 rd_valid_o,
  output logic                 frame_done_o,
  output logic                 front_bank_o,
  output logic                 blank_o
);
  import gb_lcd_pkg::*;

  localparam int PIX = LCD_W * LCD_H;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  localparam int RAM_AW = ADDR_W + 1;
`else
  localparam int RAM_AW = ADDR_W;
`endif

  logic [7:0]        wx_q, wx_d, wy_q, wy_d;
  lcd_addr_t         waddr_q, waddr_d;
  logic              front_q, front_d, blank_q, blank_d;
  logic              done_q, rdValid_q, rdMask_q;
  logic              pixWr, lastPix, rdOutOfRange;
  lcd_addr_t         rdAddr;
  logic [RAM_AW-1:0] ramWAddr, ramRAddr;
  lcd_pix_t          ramRData;

  assign pixWr   = lcd_on_i & lcd_clkena_i;
  assign lastPix = pixWr && (waddr_q == lcd_addr_t'(PIX - 1));

  // With the LCD off the write position is pinned at the origin, so turning it on restarts at (0,0).
  always_comb begin
    wx_d    = wx_q;
    wy_d    = wy_q;
    waddr_d = waddr_q;
    front_d = front_q;
    blank_d = blank_q;
    if (!lcd_on_i) begin
      wx_d    = '0;
      wy_d    = '0;
      waddr_d = '0;
      blank_d = 1'b1;
    end else if (lastPix) begin
      wx_d    = '0;
      wy_d    = '0;
      waddr_d = '0;
      blank_d = 1'b0;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
      front_d = ~front_q;
`endif
    end else if (pixWr) begin
      waddr_d = waddr_q + lcd_addr_t'(1);
      if (wx_q == 8'(LCD_W - 1)) begin
        wx_d = '0;
        wy_d = wy_q + 8'd1;
      end else begin
        wx_d = wx_q + 8'd1;
      end
    end
  end

  assign rdOutOfRange = (rd_x_i >= 8'(LCD_W)) || (rd_y_i >= 8'(LCD_H));
  assign rdAddr       = lcd_rd_addr(rd_x_i, rd_y_i);

`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  assign ramWAddr = {~front_q, waddr_q};
  assign ramRAddr = {front_q, rdAddr};
`else
  assign ramWAddr = waddr_q;
  assign ramRAddr = rdAddr;
`endif

  // The read mask is captured with the request, so a read on the swap edge sees the pre-swap state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wx_q      <= '0;
      wy_q      <= '0;
      waddr_q   <= '0;
      front_q   <= 1'b0;
      blank_q   <= 1'b1;
      done_q    <= 1'b0;
      rdValid_q <= 1'b0;
      rdMask_q  <= 1'b1;
    end else begin
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      waddr_q   <= waddr_d;
      front_q   <= front_d;
      blank_q   <= blank_d;
      done_q    <= lastPix;
      rdValid_q <= rd_req_i;
      if (rd_req_i) rdMask_q <= rdOutOfRange | blank_q;
    end
  end

  lcd_fb_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (pixWr),
    .waddr_i(ramWAddr),
    .wdata_i(lcd_data_i),
    .re_i   (rd_req_i),
    .raddr_i(ramRAddr),
    .rdata_o(ramRData)
  );

  assign rd_data_o    = rdMask_q ? 2'b00 : ramRData;
  assign rd_valid_o   = rdValid_q;
  assign frame_done_o = done_q;
  assign front_bank_o = front_q;
  assign blank_o      = blank_q;

endmodule

// File: tb/tb_lcd_capture.sv
// Self-checking bench for lcd_capture: randomized reads against a frame-level reference model.
`timescale 1ns/1ps
module tb_lcd_capture;

  localparam int W    = 160;
  localparam int H    = 144;
  localparam int PIX  = W * H;
  localparam int LAST = PIX - 1;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       lcd_on;
  logic       lcd_clkena;
  logic [1:0] lcd_data;
  logic       rd_req;
  logic [7:0] rd_x;
  logic [7:0] rd_y;
  logic [1:0] rd_data;
  logic       rd_valid;
  logic       frame_done;
  logic       front_bank;
  logic       blank;

  always #5 clk = ~clk;

  lcd_capture dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .lcd_on_i    (lcd_on),
    .lcd_clkena_i(lcd_clkena),
    .lcd_data_i  (lcd_data),
    .rd_req_i    (rd_req),
    .rd_x_i      (rd_x),
    .rd_y_i      (rd_y),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .frame_done_o(frame_done),
    .front_bank_o(front_bank),
    .blank_o     (blank)
  );

  // Reference model: whole-frame pixel store per bank, linear pixel index, displayed bank, blank flag.
  logic [1:0] mem [2][PIX];
  int         pos;
  bit         mFront, mBlank, mDone, mValid;
  logic [1:0] mRd;
  int         compareCount = 0;
  int         failCount = 0;

  task automatic expectEq(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    pos = 0; mFront = 1'b0; mBlank = 1'b1; mDone = 1'b0; mValid = 1'b0; mRd = 2'b00;
  endtask

  task automatic checkResetValues(input string tag);
    expectEq({tag, "_rd_data"},    rd_data,             2'b00);
    expectEq({tag, "_rd_valid"},   {1'b0, rd_valid},    2'b00);
    expectEq({tag, "_frame_done"}, {1'b0, frame_done},  2'b00);
    expectEq({tag, "_front_bank"}, {1'b0, front_bank},  2'b00);
    expectEq({tag, "_blank"},      {1'b0, blank},       2'b01);
  endtask

  // One clock: drive inputs, advance the model, then compare every output just after the edge.
  task automatic step(input bit on, input bit stb, input logic [1:0] d,
                      input bit req, input int x, input int y);
    lcd_on = on; lcd_clkena = stb; lcd_data = d;
    rd_req = req; rd_x = 8'(x); rd_y = 8'(y);
    if (req) begin
      if (x >= W || y >= H || mBlank) mRd = 2'b00;
      else mRd = mem[DB ? int'(mFront) : 0][y * W + x];
    end
    mValid = req;
    mDone  = 1'b0;
    if (!on) begin
      pos = 0;
      mBlank = 1'b1;
    end else if (stb) begin
      mem[DB ? int'(!mFront) : 0][pos] = d;
      if (pos == LAST) begin
        pos = 0; mBlank = 1'b0; mDone = 1'b1;
        if (DB) mFront = !mFront;
      end else begin
        pos++;
      end
    end
    @(posedge clk);
    #1;
    expectEq("rd_valid",   {1'b0, rd_valid},   {1'b0, mValid});
    expectEq("rd_data",    rd_data,            mRd);
    expectEq("frame_done", {1'b0, frame_done}, {1'b0, mDone});
    expectEq("front_bank", {1'b0, front_bank}, {1'b0, mFront});
    expectEq("blank",      {1'b0, blank},      {1'b0, mBlank});
  endtask

  task automatic readAt(input int x, input int y, input logic [1:0] want, input string tag);
    step(1'b1, 1'b0, 2'b00, 1'b1, x, y);
    expectEq({tag, "_valid"}, {1'b0, rd_valid}, 2'b01);
    expectEq(tag, rd_data, want);
  endtask

  task automatic randRead(output bit req, output int x, output int y);
    req = ($urandom_range(0, 3) == 0);
    x   = int'($urandom_range(0, 169));
    y   = int'($urandom_range(0, 153));
  endtask

  initial begin
    bit         rq;
    int         rx, ry, n;
    logic [1:0] d;

    reset_n = 1'b0; lcd_on = 1'b0; lcd_clkena = 1'b0; lcd_data = 2'b00;
    rd_req = 1'b0; rd_x = 8'd0; rd_y = 8'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("por");
    #2 reset_n = 1'b1;

    $display("[TB] partial frame then asynchronous reset");
    for (int i = 0; i < 300; i++) begin
      randRead(rq, rx, ry);
      step(1'b1, $urandom_range(0, 3) != 0, 2'($urandom), rq, rx, ry);
    end
    #2 reset_n = 1'b0;
    #1;
    checkResetValues("midrst");
    modelReset();
    lcd_on = 1'b0; lcd_clkena = 1'b0; rd_req = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;

    $display("[TB] frame 1: shade (x+y)&3");
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        randRead(rq, rx, ry);
        step(1'b1, 1'b1, 2'((x + y) & 3), rq, rx, ry);
      end
    end
    expectEq("f1_frame_done", {1'b0, frame_done}, 2'b01);
    expectEq("f1_front_bank", {1'b0, front_bank}, DB ? 2'b01 : 2'b00);
    expectEq("f1_blank",      {1'b0, blank},      2'b00);
    readAt(0, 0, 2'b00, "f1_rd_0_0");
    readAt(5, 2, 2'b11, "f1_rd_5_2");
    readAt(159, 143, 2'b10, "f1_rd_159_143");
    readAt(160, 0, 2'b00, "oor_rd_160_0");
    readAt(0, 144, 2'b00, "oor_rd_0_144");

    $display("[TB] 10000 pixels, lcd_on drop, then frame of 01");
    n = 0;
    while (n < 10000) begin
      bit stb;
      stb = ($urandom_range(0, 7) != 0);
      randRead(rq, rx, ry);
      step(1'b1, stb, 2'($urandom), rq, rx, ry);
      if (stb) n++;
    end
    for (int i = 0; i < 5; i++) begin
      randRead(rq, rx, ry);
      step(1'b0, 1'b1, 2'($urandom), rq, rx, ry);
    end
    expectEq("drop_blank", {1'b0, blank}, 2'b01);
    for (int i = 0; i < PIX; i++) begin
      randRead(rq, rx, ry);
      if (i == 100) begin rq = 1'b1; rx = 10; ry = 10; end
      step(1'b1, 1'b1, 2'b01, rq, rx, ry);
      if (i == 100) begin
        expectEq("f2_blank_rd", rd_data, 2'b00);
        expectEq("f2_blank_mid", {1'b0, blank}, 2'b01);
      end
    end
    expectEq("f2_frame_done", {1'b0, frame_done}, 2'b01);
    expectEq("f2_front_bank", {1'b0, front_bank}, 2'b00);
    for (int i = 0; i < 64; i++)
      readAt(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), 2'b01, "f2_rd_01");

    $display("[TB] frame 3: random data, read on the swap edge");
    for (int i = 0; i < PIX; i++) begin
      randRead(rq, rx, ry);
      d = 2'($urandom);
      if (i == 0) d = 2'b11;
      if (i == 3) d = 2'b10;
      if (i == 4)    begin rq = 1'b1; rx = 3; ry = 0; end
      if (i == LAST) begin rq = 1'b1; rx = 0; ry = 0; end
      step(1'b1, 1'b1, d, rq, rx, ry);
      if (i == 4)    expectEq("f3_rd_3_0_live", rd_data, DB ? 2'b01 : 2'b10);
      if (i == LAST) expectEq("f3_rd_swap_edge", rd_data, DB ? 2'b01 : 2'b11);
    end
    expectEq("f3_frame_done", {1'b0, frame_done}, 2'b01);
    expectEq("f3_front_bank", {1'b0, front_bank}, DB ? 2'b01 : 2'b00);
    readAt(0, 0, 2'b11, "f3_rd_after_swap");
    step(1'b1, 1'b0, 2'b00, 1'b0, 0, 0);
    expectEq("idle_frame_done", {1'b0, frame_done}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
